// File: rtl/adder_wb_arb_pkg.sv
// Shared types and constants for the adder Wishbone arbiter.
package adder_wb_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StDrain = 2'd2
    } arb_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    function automatic int unsigned sel_width(input int unsigned data_width,
                                              input int unsigned granule);
        return data_width / granule;
    endfunction

endpackage

// File: rtl/adder_wb_rr_pick.sv
// Combinational rotating-priority picker: first requester searching upward from last+1, mod N.
module adder_wb_rr_pick
    import adder_wb_arb_pkg::*;
#(
    parameter int unsigned  N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    always_comb begin
        int unsigned cand;
        cand   = 0;
        valid  = 1'b0;
        onehot = '0;
        idx    = '0;
        // Offset N wraps back to last itself, so it is searched with lowest priority.
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last) + k) % N;
            if (!valid && req[IW'(cand)]) begin
                valid               = 1'b1;
                onehot[IW'(cand)]   = 1'b1;
                idx                 = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/adder_wb_arbiter.sv
// Round-robin per-tenure Wishbone arbiter in front of the adder slave.
// Optional hung-transfer watchdog enabled by defining ADDER_WB_ARB_TIMEOUT_EN.
module adder_wb_arbiter
    import adder_wb_arb_pkg::*;
#(
    parameter int unsigned  NUM_MASTERS    = 2,
    parameter int unsigned  ADDR_WIDTH     = 2,
    parameter int unsigned  DATA_WIDTH     = 32,
    parameter int unsigned  GRANULE        = 8,
    parameter int unsigned  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int unsigned SEL_WIDTH      = sel_width(DATA_WIDTH, GRANULE)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    output logic [SEL_WIDTH-1:0]              s_sel_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    output logic [NUM_MASTERS-1:0]            gnt_o
);

    localparam int unsigned IDX_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDX_WIDTH-1:0]   gidx_q, gidx_d;
    logic [IDX_WIDTH-1:0]   last_q, last_d;

    logic                   pick_valid;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IDX_WIDTH-1:0]   pick_idx;

    logic [ADDR_WIDTH-1:0]  adr_arr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  dat_arr [NUM_MASTERS];
    logic [SEL_WIDTH-1:0]   sel_arr [NUM_MASTERS];

    logic cyc_sel, stb_sel, busy, drive, timeout;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign adr_arr[i] = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign dat_arr[i] = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        assign sel_arr[i] = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
    end

    adder_wb_rr_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .req    (m_cyc_i),
        .last   (last_q),
        .valid  (pick_valid),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    assign cyc_sel = m_cyc_i[gidx_q];
    assign stb_sel = m_stb_i[gidx_q];
    assign busy    = (state_q == StBusy);
    assign drive   = busy && !timeout;
    assign gnt_o   = gnt_q;

`ifdef ADDER_WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 stalled;

    // A cyc drop in the expiry cycle means release, so cyc gates the timeout.
    assign stalled = stb_sel && !(s_ack_i || s_err_i);
    assign timeout = busy && cyc_sel && stalled &&
                     (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (busy && (state_d == StBusy) && stalled) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_WIDTH'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d   = pick_onehot;
                    gidx_d  = pick_idx;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!cyc_sel) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    last_d  = gidx_q;
                end else if (timeout) begin
                    state_d = StDrain;
                end
            end
`ifdef ADDER_WB_ARB_TIMEOUT_EN
            StDrain: begin
                if (!cyc_sel) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    last_d  = gidx_q;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (drive) begin
            s_cyc_o = cyc_sel;
            s_stb_o = stb_sel;
            s_we_o  = m_we_i[gidx_q];
            s_adr_o = adr_arr[gidx_q];
            s_dat_o = dat_arr[gidx_q];
            s_sel_o = sel_arr[gidx_q];
        end
        if (busy) begin
            m_dat_o          = s_dat_i;
            m_ack_o[gidx_q]  = s_ack_i & cyc_sel & stb_sel;
            m_err_o[gidx_q]  = (s_err_i & cyc_sel & stb_sel) | timeout;
        end
    end

endmodule

// File: tb/tb_adder_wb_arbiter.sv
// Directed self-checking bench for adder_wb_arbiter with a small behavioural slave.
module tb_adder_wb_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, gnt_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i;

    logic            ack_en, err_en;
    logic [DW-1:0]   mem [4];
    int              errors = 0;
    int              checks = 0;

    always #5 clk_i = ~clk_i;

    adder_wb_arbiter dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_sel_i (m_sel),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .gnt_o   (gnt_o)
    );

    // Slave model: combinational ack/err, byte-masked writes on the clock edge.
    assign s_ack_i = ack_en & s_cyc_o & s_stb_o;
    assign s_err_i = err_en & s_cyc_o & s_stb_o;
    assign s_dat_i = mem[s_adr_o];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem[0] <= 32'h0000_0002;
            mem[1] <= 32'h0000_0011;
            mem[2] <= 32'h1234_5678;
            mem[3] <= 32'h0000_0000;
        end else if (s_ack_i && s_we_o) begin
            for (int b = 0; b < SW; b++) begin
                if (s_sel_o[b]) mem[s_adr_o][b*8 +: 8] <= s_dat_o[b*8 +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_m(input int i, input logic cyc, input logic we,
                           input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic [SW-1:0] sel);
        m_cyc[i]         = cyc;
        m_stb[i]         = cyc;
        m_we[i]          = we;
        m_adr[i*AW +: AW] = adr;
        m_dat[i*DW +: DW] = dat;
        m_sel[i*SW +: SW] = sel;
    endtask

    task automatic apply_reset();
        rst_i = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        tick();
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_i  = 1'b0;
        ack_en = 1'b1;
        err_en = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        tick();
        drive_m(0, 1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF);
        tick();
        checks++;
        if (gnt_o !== 2'b00) begin
            errors++; $display("FAIL reset_gnt: got %b want 00", gnt_o);
        end
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o} !== '0) begin
            errors++; $display("FAIL reset_slave: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h want 0",
                               s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o);
        end
        checks++;
        if ({m_ack_o, m_err_o, m_dat_o} !== '0) begin
            errors++; $display("FAIL reset_master: ack=%b err=%b dat=%h want 0",
                               m_ack_o, m_err_o, m_dat_o);
        end
        drive_m(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_read();
        drive_m(0, 1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
        #1;
        checks++;
        if ({gnt_o, s_cyc_o} !== 3'b000) begin
            errors++; $display("FAIL read_pre: gnt=%b s_cyc=%b want 00 0", gnt_o, s_cyc_o);
        end
        tick();
        checks++;
        if ({gnt_o, s_cyc_o, s_adr_o} !== {2'b01, 1'b1, 2'd0}) begin
            errors++; $display("FAIL read_gnt: gnt=%b s_cyc=%b adr=%h want 01 1 0",
                               gnt_o, s_cyc_o, s_adr_o);
        end
        checks++;
        if (m_ack_o !== 2'b01 || m_dat_o !== 32'h0000_0002) begin
            errors++; $display("FAIL read_data: ack=%b dat=%h want 01 00000002", m_ack_o, m_dat_o);
        end
        drive_m(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        tick();
        checks++;
        if ({gnt_o, s_cyc_o} !== 3'b000) begin
            errors++; $display("FAIL read_release: gnt=%b s_cyc=%b want 00 0", gnt_o, s_cyc_o);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_gnt [7];
        exp_gnt = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        apply_reset();
        drive_m(0, 1'b1, 1'b0, 2'd1, 32'h0, 4'hF);
        drive_m(1, 1'b1, 1'b0, 2'd1, 32'h0, 4'hF);
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (gnt_o !== exp_gnt[k]) begin
                errors++; $display("FAIL contention_%0d: gnt=%b want %b", k, gnt_o, exp_gnt[k]);
            end
            if (exp_gnt[k] != '0) begin
                m_cyc = m_cyc & ~exp_gnt[k];
                m_stb = m_cyc;
            end else begin
                m_cyc = 2'b11;
                m_stb = 2'b11;
            end
        end
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();
    endtask

    task automatic test_error();
        ack_en = 1'b0;
        err_en = 1'b1;
        drive_m(1, 1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
        tick();
        checks++;
        if (m_err_o !== 2'b10 || m_ack_o !== 2'b00) begin
            errors++; $display("FAIL error_fwd: err=%b ack=%b want 10 00", m_err_o, m_ack_o);
        end
        drive_m(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        ack_en = 1'b1;
        err_en = 1'b0;
        tick();
    endtask

    task automatic test_write();
        drive_m(1, 1'b1, 1'b1, 2'd3, 32'hDEAD_BEEF, 4'hF);
        tick();
        checks++;
        if ({gnt_o, s_we_o, s_adr_o, s_dat_o, s_sel_o} !== {2'b10, 1'b1, 2'd3, 32'hDEAD_BEEF, 4'hF})
        begin
            errors++; $display("FAIL write_bus: gnt=%b we=%b adr=%h dat=%h sel=%h want 10 1 3 deadbeef f",
                               gnt_o, s_we_o, s_adr_o, s_dat_o, s_sel_o);
        end
        checks++;
        if (m_ack_o !== 2'b10) begin
            errors++; $display("FAIL write_ack: ack=%b want 10", m_ack_o);
        end
        tick();
        drive_m(1, 1'b1, 1'b1, 2'd2, 32'hAABB_CCDD, 4'h3);
        tick();
        drive_m(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        checks++;
        if (mem[3] !== 32'hDEAD_BEEF || mem[2] !== 32'h1234_CCDD) begin
            errors++; $display("FAIL write_mem: mem3=%h mem2=%h want deadbeef 1234ccdd",
                               mem[3], mem[2]);
        end
        tick();
        drive_m(0, 1'b1, 1'b0, 2'd3, 32'h0, 4'hF);
        tick();
        tick();
        checks++;
        if (m_ack_o !== 2'b01 || m_dat_o !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL write_readback: ack=%b dat=%h want 01 deadbeef",
                               m_ack_o, m_dat_o);
        end
        drive_m(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        tick();
    endtask

    task automatic test_reset_mid();
        ack_en = 1'b0;
        drive_m(0, 1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
        tick();
        checks++;
        if ({gnt_o, s_cyc_o} !== 3'b011) begin
            errors++; $display("FAIL midrst_busy: gnt=%b s_cyc=%b want 01 1", gnt_o, s_cyc_o);
        end
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({gnt_o, s_cyc_o, m_ack_o, m_err_o} !== '0) begin
            errors++; $display("FAIL midrst_async: gnt=%b s_cyc=%b ack=%b err=%b want 0",
                               gnt_o, s_cyc_o, m_ack_o, m_err_o);
        end
        drive_m(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        #1;
        rst_i  = 1'b1;
        ack_en = 1'b1;
        tick();
        drive_m(0, 1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
        drive_m(1, 1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
        tick();
        checks++;
        if (gnt_o !== 2'b01) begin
            errors++; $display("FAIL midrst_priority: gnt=%b want 01", gnt_o);
        end
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int err_cnt   = 0;
        int err_k     = -1;
        int first_low = -1;
        int exp_cnt, exp_k, exp_low;
        logic [N-1:0] err_val = '0;
`ifdef ADDER_WB_ARB_TIMEOUT_EN
        exp_cnt = 1;
        exp_k   = 16;
        exp_low = 16;
`else
        exp_cnt = 0;
        exp_k   = -1;
        exp_low = -1;
`endif
        ack_en = 1'b0;
        drive_m(0, 1'b1, 1'b0, 2'd1, 32'h0, 4'hF);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (m_err_o != '0) begin
                err_cnt++;
                err_k   = k;
                err_val = m_err_o;
            end
            if (!s_cyc_o && first_low < 0) first_low = k;
        end
        checks++;
        if (err_cnt != exp_cnt || err_k != exp_k) begin
            errors++; $display("FAIL timeout_err: pulses=%0d at=%0d want %0d at %0d",
                               err_cnt, err_k, exp_cnt, exp_k);
        end
        checks++;
        if (first_low != exp_low) begin
            errors++; $display("FAIL timeout_cyc: s_cyc first low at %0d want %0d",
                               first_low, exp_low);
        end
`ifdef ADDER_WB_ARB_TIMEOUT_EN
        checks++;
        if (err_val !== 2'b01 || gnt_o !== 2'b01) begin
            errors++; $display("FAIL timeout_drain: err=%b gnt=%b want 01 01", err_val, gnt_o);
        end
`endif
        drive_m(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        tick();
        checks++;
        if ({gnt_o, s_cyc_o} !== 3'b000) begin
            errors++; $display("FAIL timeout_idle: gnt=%b s_cyc=%b want 00 0", gnt_o, s_cyc_o);
        end
        ack_en = 1'b1;
        drive_m(1, 1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
        tick();
        checks++;
        if (gnt_o !== 2'b10 || m_ack_o !== 2'b10 || m_dat_o !== 32'h0000_0002) begin
            errors++; $display("FAIL timeout_recover: gnt=%b ack=%b dat=%h want 10 10 00000002",
                               gnt_o, m_ack_o, m_dat_o);
        end
        drive_m(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_contention();
        test_error();
        test_write();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_wb_arbiter.md
# adder_wb_arbiter

Wishbone arbiter that shares the single `adder` Wishbone slave between `NUM_MASTERS` bus masters. Arbitration is round-robin per bus tenure: a granted master keeps the slave until it drops `cyc`. The block sits between the masters (CPU port, DMA/test master) and the `adder` slave. It also supplies an optional watchdog that terminates hung transfers with an error.

## Interface
- `NUM_MASTERS`, 2, number of requesting masters (2..8)
- `ADDR_WIDTH`, 2, word address width, matches slave
- `DATA_WIDTH`, 32, data width
- `GRANULE`, 8, byte-select granule; `SEL_WIDTH = DATA_WIDTH/GRANULE`
- `TIMEOUT_CYCLES`, 16, watchdog limit in cycles (only with `ADDER_WB_ARB_TIMEOUT_EN`)

Ports:
- `clk_i` in 1: single clock, all logic on rising edge
- `rst_i` in 1: reset, asynchronous assert, active-low
- `m_cyc_i` in N: per-master cycle
- `m_stb_i` in N: per-master strobe
- `m_we_i` in N: per-master write enable
- `m_adr_i` in N*ADDR_WIDTH: master i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`
- `m_dat_i` in N*DATA_WIDTH: write data, same packing
- `m_sel_i` in N*SEL_WIDTH: byte selects, same packing
- `m_dat_o` out DATA_WIDTH: slave read data, broadcast to all masters
- `m_ack_o` out N: per-master ack
- `m_err_o` out N: per-master error
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1: slave cycle, strobe, write enable
- `s_adr_o` out ADDR_WIDTH, `s_dat_o` out DATA_WIDTH, `s_sel_o` out SEL_WIDTH: slave address, write data, byte selects
- `s_dat_i` in DATA_WIDTH, `s_ack_i` in 1, `s_err_i` in 1: slave response
- `gnt_o` out N: one-hot registered grant, 0 when idle

## Operation
- States: IDLE, BUSY, DRAIN (DRAIN exists only with the macro).
- IDLE:
  - If any `m_cyc_i` bit is set, pick the first requester searching from `last+1` upward, modulo N.
  - Register the winner into `gnt_o`; go to BUSY.
  - No slave signals are driven.
- BUSY:
  - `s_cyc_o = m_cyc_i[g]`; `s_stb_o`, `s_we_o`, `s_adr_o`, `s_dat_o`, `s_sel_o` are muxed combinationally from master g.
  - `m_ack_o[g] = s_ack_i & m_cyc_i[g] & m_stb_i[g]`; `m_err_o[g]` is formed the same way from `s_err_i`. All other ack/err bits are 0.
  - `m_dat_o = s_dat_i`.
- Release: when `m_cyc_i[g]` is 0 in BUSY, go to IDLE, set `last <= g`, clear `gnt_o`.
- Non-granted masters stall; their cyc/stb are ignored until they are granted.
- Arbitration is not preemptive. A multi-beat master holding `cyc` keeps the slave indefinitely (without the macro).
- Slave outputs are all 0 whenever the state is not BUSY.

## Timing
- Reset:
  - `gnt_o = 0`, state IDLE, `last = N-1` so master 0 wins first.
  - All `s_*` outputs are 0; `m_ack_o = 0`, `m_err_o = 0`, `m_dat_o = 0`.
- Reset asserted mid-transfer: `s_cyc_o` drops asynchronously; no ack/err is issued.
- Latency: a master raising `cyc` in IDLE at cycle t sees `gnt_o` and `s_cyc_o` at t+1. The first ack can occur at t+1 (the slave acks combinationally).
- After release there is a minimum of one IDLE cycle before the next grant.
- Simultaneous requests in IDLE resolve by round-robin. A lone requester wins regardless of `last`.
- A master dropping `cyc` in the same cycle another raises it: the release completes, and the new master is arbitrated in the following IDLE cycle.

## Configuration
- `ADDER_WB_ARB_TIMEOUT_EN` defined:
  - A counter runs in BUSY while `s_stb_o` is 1 and `s_ack_i | s_err_i` is 0. It clears on ack/err, on stb low, and on leaving BUSY.
  - At count == `TIMEOUT_CYCLES-1`, pulse `m_err_o[g]` for one cycle, force the `s_*` outputs to 0, and go to DRAIN.
  - DRAIN waits for `m_cyc_i[g] = 0`, then goes to IDLE with `last <= g`.
  - If `cyc` drops in the timeout cycle itself, release takes priority and no err is issued.
- Not defined: no counter, no DRAIN state; `m_err_o` only forwards `s_err_i`.

## Structure
- Package `adder_wb_arb_pkg` holds:
  - the state enum (IDLE, BUSY, DRAIN);
  - the `SEL_WIDTH` derivation;
  - the default `TIMEOUT_CYCLES` constant.
- One sub-module, `adder_wb_rr_pick`: combinational rotating-priority picker. Inputs are the request vector and `last`; outputs are a one-hot winner and an index.
- The top level holds the FSM, grant register, bus muxes and watchdog.

## Test plan
- Reset, then master 0 reads `adr=0`: `gnt_o=01` at t+1; `m_ack_o=01`; `m_dat_o=32'h00000002`; `s_*` outputs are 0 before t+1.
- Both masters raise `cyc` in the same cycle after reset: master 0 is granted first, then master 1 after master 0 drops `cyc` plus one IDLE cycle. Repeated contention alternates 0,1,0,1.
- Master 1 writes `dat=32'hDEADBEEF`, `sel=4'hF` while master 0 idles: slave sees exactly those values; `m_ack_o=10`; `m_ack_o[0]` stays 0.
- Assert `rst_i` low mid-BUSY: `s_cyc_o` and `gnt_o` go to 0 immediately. After reset release, master 0 has priority.
- With macro, and the slave's ack tied low: exactly one `m_err_o[g]` pulse at cycle `TIMEOUT_CYCLES` after stb; `s_cyc_o` goes to 0; IDLE is reached after the master drops `cyc`.
- Without macro, same stimulus: no err, `s_cyc_o` held until the master drops `cyc`.
